// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline hazard/interrupt controller.
//   REG_W            : GPR index width
//   *_DEF            : default MDU occupancy and counter width
//   ST_*             : interrupt sequencer state encoding
package pipe_ctrl_pkg;
    localparam int REG_W           = 5;
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W_DEF       = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_INJECT = 2'd2;
endpackage

// File: rtl/mdu_busy_counter.sv
// Tracks how long the multi-cycle MULT/DIV unit still owns HI/LO.
// Ports:
//   clk    in  rising-edge clock
//   reset  in  synchronous, active-high; clears the counter
//   start  in  MULT/DIV issuing this cycle
//   is_div in  qualifies start: 1 = divide
//   busy   out counter non-zero
module mdu_busy_counter #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // A start while busy is dropped: the hazard logic holds any issuer
    // back until the count reaches zero, so it never happens in practice.
    always_comb begin
        count_d = count_q;
        if (count_q == '0) begin
            if (start) begin
                count_d = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            end
        end else begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign busy = (count_q != '0);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/interrupt sequencer for the 5-stage pipeline.
// Detects load-use and MDU hazards, and injects a pending interrupt at a
// clean boundary via a 3-state FSM (IDLE/DRAIN/INJECT).
// Ports:
//   clk, reset                 clock; synchronous active-high reset
//   rs_d, rt_d                 D-stage source registers
//   reg_write_e, mem_to_reg_e  E-stage writes GPR / is a load
//   write_reg_e                E-stage destination register
//   mdu_start_e, mdu_is_div_e  MULT/DIV issuing in E, divide qualifier
//   mdu_use_d                  D instruction touches HI/LO or the MDU
//   branch_taken_d             D-stage branch/jump taken
//   irq_pending, exl           CP0 interrupt request and EXL
//   stall_f, stall_d, flush_e  pipeline stall/flush controls
//   cancel_f, irq_req_f        IF/ID CancelF and InterruptRequest
//   pc_sel_exc, exl_set        exception vector select, EPC/EXL pulse
//   mdu_busy                   MDU owns HI/LO
//   dbg_state_o                FSM state for observation
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] rs_d,
    input  logic [REG_W-1:0] rt_d,
    input  logic             reg_write_e,
    input  logic             mem_to_reg_e,
    input  logic [REG_W-1:0] write_reg_e,
    input  logic             mdu_start_e,
    input  logic             mdu_is_div_e,
    input  logic             mdu_use_d,
    input  logic             branch_taken_d,
    input  logic             irq_pending,
    input  logic             exl,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_e,
    output logic             cancel_f,
    output logic             irq_req_f,
    output logic             pc_sel_exc,
    output logic             exl_set,
    output logic             mdu_busy,
    output logic [1:0]       dbg_state_o
);
    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       busy_raw;
    logic       load_use;
    logic       mdu_stall;
    logic       stall_raw;
    logic       inject;

    mdu_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_busy (
        .clk    (clk),
        .reset  (reset),
        .start  (mdu_start_e),
        .is_div (mdu_is_div_e),
        .busy   (busy_raw)
    );

    assign inject    = (state_q == ST_INJECT);
    assign load_use  = mem_to_reg_e & reg_write_e & (write_reg_e != '0) &
                       ((write_reg_e == rs_d) | (write_reg_e == rt_d));
    assign mdu_stall = mdu_use_d & (busy_raw | mdu_start_e);
    // The interrupt slot replaces the D instruction, so no stall then.
    assign stall_raw = (load_use | mdu_stall) & ~inject;

    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: begin
                if (irq_pending & ~exl) begin
                    state_d = (~stall_raw & ~busy_raw) ? ST_INJECT : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Withdrawal takes priority over a boundary becoming free.
                if (~irq_pending | exl) begin
                    state_d = ST_IDLE;
                end else if (~stall_raw & ~busy_raw) begin
                    state_d = ST_INJECT;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs are forced low for the whole reset cycle, whatever state held.
    assign stall_f     = ~reset & stall_raw;
    assign stall_d     = ~reset & stall_raw;
    assign flush_e     = ~reset & (stall_raw | inject);
    assign cancel_f    = ~reset & branch_taken_d & ~stall_raw & ~inject;
    assign irq_req_f   = ~reset & inject;
    assign pc_sel_exc  = ~reset & inject;
    assign exl_set     = ~reset & inject;
    assign mdu_busy    = ~reset & busy_raw;
    assign dbg_state_o = reset ? ST_IDLE : state_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs_d, rt_d, write_reg_e;
    logic       reg_write_e, mem_to_reg_e, mdu_start_e, mdu_is_div_e;
    logic       mdu_use_d, branch_taken_d, irq_pending, exl;
    logic       stall_f, stall_d, flush_e, cancel_f, irq_req_f;
    logic       pc_sel_exc, exl_set, mdu_busy;
    logic [1:0] dbg_state;

    // Output vector: [9]stall_f [8]stall_d [7]flush_e [6]cancel_f
    // [5]irq_req_f [4]pc_sel_exc [3]exl_set [2]mdu_busy [1:0]state
    logic [9:0] dut_out;
    logic [9:0] last_out;
    logic [9:0] exp_q[$];
    string      tag_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    // Reference model state
    logic [1:0] m_state;
    logic [3:0] m_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .rs_d           (rs_d),
        .rt_d           (rt_d),
        .reg_write_e    (reg_write_e),
        .mem_to_reg_e   (mem_to_reg_e),
        .write_reg_e    (write_reg_e),
        .mdu_start_e    (mdu_start_e),
        .mdu_is_div_e   (mdu_is_div_e),
        .mdu_use_d      (mdu_use_d),
        .branch_taken_d (branch_taken_d),
        .irq_pending    (irq_pending),
        .exl            (exl),
        .stall_f        (stall_f),
        .stall_d        (stall_d),
        .flush_e        (flush_e),
        .cancel_f       (cancel_f),
        .irq_req_f      (irq_req_f),
        .pc_sel_exc     (pc_sel_exc),
        .exl_set        (exl_set),
        .mdu_busy       (mdu_busy),
        .dbg_state_o    (dbg_state)
    );

    assign dut_out = {stall_f, stall_d, flush_e, cancel_f, irq_req_f,
                      pc_sel_exc, exl_set, mdu_busy, dbg_state};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] model_out();
        logic busy, lu, ms, inj, stl;
        if (reset) return 10'd0;
        busy = (m_cnt != 0);
        lu   = mem_to_reg_e && reg_write_e && write_reg_e != 0 &&
               (write_reg_e == rs_d || write_reg_e == rt_d);
        ms   = mdu_use_d && (busy || mdu_start_e);
        inj  = (m_state == 2'd2);
        stl  = (lu || ms) && !inj;
        return {stl, stl, stl || inj, branch_taken_d && !stl && !inj,
                inj, inj, inj, busy, m_state};
    endfunction

    task automatic model_step();
        logic [9:0] o;
        logic       free;
        o = model_out();
        if (reset) begin
            m_state = 2'd0;
            m_cnt   = 4'd0;
        end else begin
            free = !o[8] && (m_cnt == 0);
            case (m_state)
                2'd0: if (irq_pending && !exl) m_state = free ? 2'd2 : 2'd1;
                2'd1: begin
                    if (!irq_pending || exl) m_state = 2'd0;
                    else if (free)           m_state = 2'd2;
                end
                default: m_state = 2'd0;
            endcase
            if (m_cnt == 0) begin
                if (mdu_start_e) m_cnt = mdu_is_div_e ? 4'd10 : 4'd5;
            end else begin
                m_cnt = m_cnt - 4'd1;
            end
        end
    endtask

    // Inputs are already applied; push expectation, compare at the falling
    // edge, advance the model, then return just after the next rising edge.
    task automatic cycle(input string tag);
        exp_q.push_back(model_out());
        tag_q.push_back(tag);
        @(negedge clk);
        last_out = dut_out;
        check_eq(tag_q.pop_front(), dut_out, exp_q.pop_front());
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        reset = 0; rs_d = 0; rt_d = 0; write_reg_e = 0;
        reg_write_e = 0; mem_to_reg_e = 0; mdu_start_e = 0; mdu_is_div_e = 0;
        mdu_use_d = 0; branch_taken_d = 0; irq_pending = 0; exl = 0;
    endtask

    task automatic issue_div(input logic use_d);
        mdu_start_e = 1; mdu_is_div_e = 1; mdu_use_d = use_d;
        cycle("div_issue");
        mdu_start_e = 0; mdu_is_div_e = 0;
    endtask

    int cnt;

    initial begin
        m_state = 2'd0;
        m_cnt   = 4'd0;
        clr_inputs();
        // Reset with noisy inputs: all outputs zero
        reset = 1; irq_pending = 1; branch_taken_d = 1; mdu_use_d = 1; mdu_start_e = 1;
        cycle("reset0");
        check_eq("reset_outs", last_out, 10'd0);
        cycle("reset1");
        clr_inputs();
        cycle("idle");

        // Load-use on rs
        mem_to_reg_e = 1; reg_write_e = 1; write_reg_e = 5; rs_d = 5; rt_d = 7;
        cycle("lu_rs");
        check_eq("lu_stall_flush", last_out[9:7], 3'b111);
        clr_inputs();
        cycle("lu_release");
        check_eq("lu_released", last_out[9:7], 3'b000);
        // Load-use on rt
        mem_to_reg_e = 1; reg_write_e = 1; write_reg_e = 9; rs_d = 1; rt_d = 9;
        cycle("lu_rt");
        // Load to $0 never stalls
        write_reg_e = 0; rs_d = 0; rt_d = 0;
        cycle("lu_r0");
        check_eq("lu_r0_nostall", last_out[8], 1'b0);
        clr_inputs();

        // DIV + mflo: stall issue cycle plus 10
        cnt = 0;
        issue_div(1'b1);
        cnt += last_out[8];
        mdu_use_d = 1;
        for (int i = 0; i < 11; i++) begin
            cycle("div_mflo");
            cnt += last_out[8];
        end
        check_eq("div_stall_cycles", cnt, 11);
        check_eq("div_released", last_out[8], 1'b0);
        clr_inputs();

        // MULT: busy exactly 5 cycles
        cnt = 0;
        mdu_start_e = 1;
        cycle("mult_issue");
        cnt += last_out[2];
        mdu_start_e = 0;
        for (int i = 0; i < 7; i++) begin
            cycle("mult_busy");
            cnt += last_out[2];
        end
        check_eq("mult_busy_cycles", cnt, 5);

        // Interrupt with free pipeline
        irq_pending = 1;
        cycle("irq_accept");
        check_eq("irq_not_yet", last_out[5:3], 3'b000);
        exl = 1;
        cycle("irq_inject");
        check_eq("irq_inject_outs", last_out[5:3], 3'b111);
        check_eq("irq_inject_state", last_out[1:0], 2'd2);
        cycle("irq_after");
        check_eq("irq_back_idle", last_out[1:0], 2'd0);
        clr_inputs();

        // Interrupt with 3 DIV cycles left
        issue_div(1'b0);
        for (int i = 0; i < 7; i++) cycle("div_run");
        irq_pending = 1;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cycle("irq_drain");
            cnt += (last_out[1:0] == 2'd1);
        end
        cycle("irq_drain_inject");
        check_eq("drain_cycles", cnt, 3);
        check_eq("drain_then_inject", last_out[5:3], 3'b111);
        exl = 1;
        cycle("drain_exl");
        clr_inputs();

        // Interrupt withdrawn in DRAIN
        issue_div(1'b0);
        irq_pending = 1;
        for (int i = 0; i < 3; i++) cycle("wd_drain");
        check_eq("wd_in_drain", last_out[1:0], 2'd1);
        irq_pending = 0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cycle("wd_idle");
            cnt += last_out[3];
        end
        check_eq("wd_no_exl_set", cnt, 0);
        check_eq("wd_state_idle", last_out[1:0], 2'd0);

        // Branch and interrupt together
        irq_pending = 1;
        cycle("br_irq_accept");
        branch_taken_d = 1; exl = 1;
        cycle("br_irq_inject");
        check_eq("br_irq_cancel", last_out[6], 1'b0);
        check_eq("br_irq_req", last_out[5], 1'b1);
        clr_inputs();
        branch_taken_d = 1;
        cycle("br_alone");
        check_eq("br_alone_cancel", last_out[6], 1'b1);
        mem_to_reg_e = 1; reg_write_e = 1; write_reg_e = 3; rt_d = 3;
        cycle("br_stall");
        check_eq("br_stall_defer", last_out[6], 1'b0);
        clr_inputs();
        branch_taken_d = 1;
        cycle("br_after_stall");
        check_eq("br_after_stall", last_out[6], 1'b1);
        clr_inputs();

        // Reset mid-DRAIN
        issue_div(1'b0);
        irq_pending = 1;
        cycle("rst_enter_drain");
        cycle("rst_drain");
        check_eq("rst_pre_drain", last_out[1:0], 2'd1);
        reset = 1;
        cycle("rst_in_drain");
        check_eq("rst_drain_zero", last_out, 10'd0);
        clr_inputs();
        cycle("rst_after");
        check_eq("rst_after_state", last_out[1:0], 2'd0);
        check_eq("rst_after_busy", last_out[2], 1'b0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            reset          = ($urandom_range(0, 39) == 0);
            rs_d           = 5'($urandom_range(0, 3));
            rt_d           = 5'($urandom_range(0, 3));
            write_reg_e    = 5'($urandom_range(0, 3));
            reg_write_e    = 1'($urandom_range(0, 1));
            mem_to_reg_e   = 1'($urandom_range(0, 1));
            mdu_start_e    = ($urandom_range(0, 5) == 0);
            mdu_is_div_e   = 1'($urandom_range(0, 1));
            mdu_use_d      = ($urandom_range(0, 3) == 0);
            branch_taken_d = 1'($urandom_range(0, 1));
            irq_pending    = ($urandom_range(0, 3) == 0);
            exl            = ($urandom_range(0, 5) == 0);
            cycle("random");
        end
        clr_inputs();
        cycle("final_idle");

        check_eq("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
